e203_subsys_clksw_ctrl: RTL and testbench
=========================================

Name: e203_subsys_clksw_ctrl

Overview:
- Sequencing controller directly upstream of the glitch-free clock mux; sole driver of its sel1 input.
- Runs on the always-on reference clock, which is also the mux clk0 source.
- Switches the mux to the PLL clock (clk1) only after PLL lock has been stable for a programmed window.
- Holds the selection steady while the mux handshake settles, and auto-reverts to clk0 on loss of lock, with sticky status and an interrupt.

Parameters:
- LOCK_WAIT, 16: consecutive synchronized-lock cycles required before switching to clk1.
- SETTLE_CYC, 8: cycles busy stays high after any sel1 change; must cover the mux's 3-stage cross-sync on the slower clock.
- TMO_CYC, 4096: maximum cycles in WAIT_LOCK before timeout.
- CNT_W, 12: counter width; must hold max(LOCK_WAIT, SETTLE_CYC, TMO_CYC).

Ports:
- clk  input  1  always-on reference clock.
- rst  input  1  synchronous, active-high reset.
- pll_lock  input  1  PLL lock indicator, asynchronous to clk.
- sw_req  input  1  level request from CSR; 1 = run on PLL clock, 0 = run on reference clock.
- sts_clr  input  1  single-cycle pulse; clears lock_lost and lock_tmo.
- irq_en  input  1  interrupt enable.
- sel1  output  1  to mux sel1; 1 selects clk1.
- busy  output  1  switch in progress.
- cur_sel  output  1  1 only in SEL1 (settled on PLL clock).
- lock_lost  output  1  sticky: lock dropped while on, or switching to, clk1.
- lock_tmo  output  1  sticky: lock not achieved within TMO_CYC.
- irq  output  1  irq_en & (lock_lost | lock_tmo), registered.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on port rst.
- Reset: state = SEL0; all counters 0; sel1=0, busy=0, cur_sel=0, lock_lost=0, lock_tmo=0, irq=0.
- Lock synchronizer: pll_lock passes through a 2-flop synchronizer to give lock_s, which lags pll_lock by 2 cycles. Flops reset to 0.
- Outputs: all registered, decoded from next-state.
  - sel1 = 1 in SW_TO1 and SEL1.
  - busy = 1 in WAIT_LOCK, SW_TO1 and SW_TO0.
- Interrupt/status gating: arm = sw_req & ~lock_lost & ~lock_tmo. Re-arm after a fault requires sts_clr.
- FSM states: SEL0, WAIT_LOCK, SW_TO1, SEL1, SW_TO0.
  - SEL0: if arm, go to WAIT_LOCK and clear lock_cnt and tmo_cnt.
  - WAIT_LOCK:
    - if ~sw_req, go to SEL0.
    - else lock_cnt increments while lock_s=1 and resets to 0 when lock_s=0.
    - tmo_cnt increments every cycle.
    - lock_cnt == LOCK_WAIT-1 with lock_s=1: go to SW_TO1, clear set_cnt.
    - otherwise, tmo_cnt == TMO_CYC-1: set lock_tmo, go to SEL0. Lock completion wins over timeout in the same cycle.
  - SW_TO1:
    - set_cnt counts to SETTLE_CYC-1, then go to SEL1.
    - lock_s=0 at any point: set lock_lost, go to SW_TO0, clear set_cnt.
    - ~sw_req is ignored until settled; no mid-settle reversal except on lock loss.
  - SEL1:
    - lock_s=0: set lock_lost, go to SW_TO0.
    - else ~sw_req: go to SW_TO0.
  - SW_TO0: set_cnt counts to SETTLE_CYC-1, then go to SEL0. All inputs are ignored during the settle.
- Sticky bits:
  - set has priority over sts_clr in the same cycle.
  - sts_clr has no effect on state or sel1.
- Latencies:
  - sw_req rise with lock already stable gives sel1 rise after 1 + LOCK_WAIT cycles.
  - cur_sel rises SETTLE_CYC cycles after sel1.
  - Lock loss in SEL1 drops sel1 3 cycles after pll_lock falls (2 sync + 1 register).
- sel1 never toggles more than once per SETTLE_CYC window.
- rst mid-switch: sel1 returns to 0 immediately. The mux's own reset handles any in-flight handshake.

Decomposition:
- Shared package e203_subsys_clksw_pkg holds:
  - the state encoding, 3-bit localparams ST_SEL0..ST_SW_TO0;
  - default LOCK_WAIT, SETTLE_CYC and TMO_CYC constants.
- One natural sub-module: e203_subsys_clksw_sync, a 2-flop synchronizer with synchronous active-high reset, reusable for other async status inputs.

Test Plan:
- Normal switch: pll_lock=1 from reset, sw_req=1 at cycle 10, LOCK_WAIT=16, SETTLE_CYC=8 -> sel1 rises at cycle 27, cur_sel at 35, busy low at 35, no status bits set.
- Lock glitch: lock_s drops for 1 cycle at lock_cnt=10 -> lock_cnt restarts from 0; sel1 rise is delayed by 11 cycles.
- Timeout: sw_req=1, pll_lock=0 -> lock_tmo=1 after 4096 cycles, back to SEL0, sw_req held 1 does not re-arm; sts_clr -> WAIT_LOCK next cycle.
- Lock loss in SEL1: drop pll_lock -> sel1=0 3 cycles later, lock_lost=1, irq=1 if irq_en, busy for 8 cycles, then SEL0, no auto re-arm.
- Lock loss during SW_TO1 at set_cnt=3 -> immediate SW_TO0, full 8-cycle settle, sel1 pulse width ≥ 4 cycles, lock_lost=1.
- Simultaneous sts_clr and lock-loss set -> lock_lost stays 1. Reset asserted in SEL1 -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/e203_subsys_clksw_ctrl_pkg.sv
// Shared definitions for the PLL/reference clock-switch sequencer:
// state encoding and default timing constants.
package e203_subsys_clksw_pkg;

   localparam logic [2:0] ST_SEL0      = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_SW_TO1    = 3'd2;
   localparam logic [2:0] ST_SEL1      = 3'd3;
   localparam logic [2:0] ST_SW_TO0    = 3'd4;

   typedef enum logic [2:0] {
      SEL0      = ST_SEL0,
      WAIT_LOCK = ST_WAIT_LOCK,
      SW_TO1    = ST_SW_TO1,
      SEL1      = ST_SEL1,
      SW_TO0    = ST_SW_TO0
   } clksw_state_t;

   localparam int LOCK_WAIT_DEF  = 16;
   localparam int SETTLE_CYC_DEF = 8;
   localparam int TMO_CYC_DEF    = 4096;
   localparam int CNT_W_DEF      = 12;

endpackage

// File: rtl/e203_subsys_clksw_ctrl_if.sv
// Control/status bundle between the CSR block and the clock-switch sequencer.
interface e203_subsys_clksw_ctrl_if;
   import e203_subsys_clksw_pkg::*;

   logic pll_lock;
   logic sw_req;
   logic sts_clr;
   logic irq_en;
   logic sel1;
   logic busy;
   logic cur_sel;
   logic lock_lost;
   logic lock_tmo;
   logic irq;

   modport master (
      output pll_lock, sw_req, sts_clr, irq_en,
      input  sel1, busy, cur_sel, lock_lost, lock_tmo, irq
   );

   modport slave (
      input  pll_lock, sw_req, sts_clr, irq_en,
      output sel1, busy, cur_sel, lock_lost, lock_tmo, irq
   );

endinterface

// File: rtl/e203_subsys_clksw_sync.sv
// Two-flop synchronizer for a slow asynchronous status level.
module e203_subsys_clksw_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/e203_subsys_clksw_ctrl.sv
// Sequencer driving the glitch-free mux sel1: waits for stable PLL lock,
// holds selection through mux settling, and falls back to clk0 on lock loss.
module e203_subsys_clksw_ctrl
   import e203_subsys_clksw_pkg::*;
#(
   parameter int LOCK_WAIT  = LOCK_WAIT_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int TMO_CYC    = TMO_CYC_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   e203_subsys_clksw_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT - 1);
   localparam logic [CNT_W-1:0] SET_LAST  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);

   logic             lock_s;
   logic             arm;
   clksw_state_t     state_reg;
   logic [CNT_W-1:0] lock_cnt_reg;
   logic [CNT_W-1:0] tmo_cnt_reg;
   logic [CNT_W-1:0] set_cnt_reg;
   logic             sel1_reg;
   logic             busy_reg;
   logic             cur_sel_reg;
   logic             lock_lost_reg;
   logic             lock_tmo_reg;
   logic             irq_reg;

   e203_subsys_clksw_sync u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.pll_lock),
      .q   (lock_s)
   );

   // A latched fault blocks re-arming until software clears it.
   assign arm = bus.sw_req & ~lock_lost_reg & ~lock_tmo_reg;

   // Outputs are written alongside each state change so they always reflect the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= SEL0;
         lock_cnt_reg  <= '0;
         tmo_cnt_reg   <= '0;
         set_cnt_reg   <= '0;
         sel1_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         cur_sel_reg   <= 1'b0;
         lock_lost_reg <= 1'b0;
         lock_tmo_reg  <= 1'b0;
         irq_reg       <= 1'b0;
      end else begin
         irq_reg <= bus.irq_en & (lock_lost_reg | lock_tmo_reg);
         if (bus.sts_clr) begin
            lock_lost_reg <= 1'b0;
            lock_tmo_reg  <= 1'b0;
         end
         case (state_reg)
            SEL0: begin
               if (arm) begin
                  state_reg    <= WAIT_LOCK;
                  busy_reg     <= 1'b1;
                  lock_cnt_reg <= '0;
                  tmo_cnt_reg  <= '0;
               end
            end
            WAIT_LOCK: begin
               if (!bus.sw_req) begin
                  state_reg <= SEL0;
                  busy_reg  <= 1'b0;
               end else if (lock_s && (lock_cnt_reg == LOCK_LAST)) begin
                  state_reg   <= SW_TO1;
                  sel1_reg    <= 1'b1;
                  set_cnt_reg <= '0;
               end else begin
                  lock_cnt_reg <= lock_s ? lock_cnt_reg + 1'b1 : '0;
                  tmo_cnt_reg  <= tmo_cnt_reg + 1'b1;
                  if (tmo_cnt_reg == TMO_LAST) begin
                     lock_tmo_reg <= 1'b1;
                     state_reg    <= SEL0;
                     busy_reg     <= 1'b0;
                  end
               end
            end
            SW_TO1: begin
               if (!lock_s) begin
                  lock_lost_reg <= 1'b1;
                  state_reg     <= SW_TO0;
                  sel1_reg      <= 1'b0;
                  set_cnt_reg   <= '0;
               end else if (set_cnt_reg == SET_LAST) begin
                  state_reg   <= SEL1;
                  busy_reg    <= 1'b0;
                  cur_sel_reg <= 1'b1;
               end else begin
                  set_cnt_reg <= set_cnt_reg + 1'b1;
               end
            end
            SEL1: begin
               if (!lock_s || !bus.sw_req) begin
                  if (!lock_s) begin
                     lock_lost_reg <= 1'b1;
                  end
                  state_reg   <= SW_TO0;
                  sel1_reg    <= 1'b0;
                  busy_reg    <= 1'b1;
                  cur_sel_reg <= 1'b0;
                  set_cnt_reg <= '0;
               end
            end
            SW_TO0: begin
               if (set_cnt_reg == SET_LAST) begin
                  state_reg <= SEL0;
                  busy_reg  <= 1'b0;
               end else begin
                  set_cnt_reg <= set_cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg   <= SEL0;
               sel1_reg    <= 1'b0;
               busy_reg    <= 1'b0;
               cur_sel_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sel1      = sel1_reg;
   assign bus.busy      = busy_reg;
   assign bus.cur_sel   = cur_sel_reg;
   assign bus.lock_lost = lock_lost_reg;
   assign bus.lock_tmo  = lock_tmo_reg;
   assign bus.irq       = irq_reg;

endmodule

// File: tb/tb_e203_subsys_clksw_ctrl.sv
// Directed latency scenarios plus randomized traffic, checked every cycle
// against a timestamp/queue-based behavioural model of the switch sequence.
module tb_e203_subsys_clksw_ctrl;

   localparam int LOCK_WAIT  = 16;
   localparam int SETTLE_CYC = 8;
   localparam int TMO_CYC    = 4096;

   // Model phases of the switch sequence.
   localparam int P_IDLE = 0;
   localparam int P_WAIT = 1;
   localparam int P_RISE = 2;
   localparam int P_ON   = 3;
   localparam int P_FALL = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   int   phase;
   int   run_len;
   int   waited;
   int   settled;
   bit   m_lost, m_tmo, m_irq;
   bit   lock_pipe[$];

   e203_subsys_clksw_ctrl_if bus ();

   e203_subsys_clksw_ctrl #(
      .LOCK_WAIT  (LOCK_WAIT),
      .SETTLE_CYC (SETTLE_CYC),
      .TMO_CYC    (TMO_CYC),
      .CNT_W      (12)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   // Reference behaviour for one clock edge, from the inputs present at that edge.
   task automatic model_step();
      bit ls, set_lost, set_tmo, irq_n;
      if (rst) begin
         phase = P_IDLE; run_len = 0; waited = 0; settled = 0;
         m_lost = 0; m_tmo = 0; m_irq = 0;
         lock_pipe = '{1'b0, 1'b0};
         return;
      end
      ls = lock_pipe[0];
      void'(lock_pipe.pop_front());
      lock_pipe.push_back(bus.pll_lock);
      irq_n    = bus.irq_en & (m_lost | m_tmo);
      set_lost = 0;
      set_tmo  = 0;
      case (phase)
         P_IDLE: if (bus.sw_req && !m_lost && !m_tmo) begin
            phase = P_WAIT; run_len = 0; waited = 0;
         end
         P_WAIT: begin
            if (!bus.sw_req) phase = P_IDLE;
            else begin
               run_len = ls ? run_len + 1 : 0;
               waited++;
               if (run_len == LOCK_WAIT) begin
                  phase = P_RISE; settled = 0;
               end else if (waited == TMO_CYC) begin
                  set_tmo = 1; phase = P_IDLE;
               end
            end
         end
         P_RISE: begin
            if (!ls) begin
               set_lost = 1; phase = P_FALL; settled = 0;
            end else begin
               settled++;
               if (settled == SETTLE_CYC) phase = P_ON;
            end
         end
         P_ON: begin
            if (!ls) set_lost = 1;
            if (!ls || !bus.sw_req) begin
               phase = P_FALL; settled = 0;
            end
         end
         default: begin
            settled++;
            if (settled == SETTLE_CYC) phase = P_IDLE;
         end
      endcase
      if (bus.sts_clr) begin m_lost = 0; m_tmo = 0; end
      if (set_lost) m_lost = 1;
      if (set_tmo)  m_tmo  = 1;
      m_irq = irq_n;
   endtask

   task automatic compare_all();
      check_eq("sel1",      bus.sel1,      (phase == P_RISE || phase == P_ON));
      check_eq("busy",      bus.busy,      (phase == P_WAIT || phase == P_RISE || phase == P_FALL));
      check_eq("cur_sel",   bus.cur_sel,   (phase == P_ON));
      check_eq("lock_lost", bus.lock_lost, m_lost);
      check_eq("lock_tmo",  bus.lock_tmo,  m_tmo);
      check_eq("irq",       bus.irq,       m_irq);
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   function automatic logic out_sel(input int which);
      case (which)
         0:       return bus.sel1;
         1:       return bus.cur_sel;
         2:       return bus.busy;
         default: return bus.lock_tmo;
      endcase
   endfunction

   // Ticks until the selected output equals val; an expired bound leaves n at limit.
   task automatic tick_until(input int which, input logic val, input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (out_sel(which) !== val && n < limit);
   endtask

   task automatic do_reset(input logic lock);
      rst = 1'b1;
      bus.pll_lock = lock; bus.sw_req = 1'b0; bus.sts_clr = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d simulation did not complete", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n;
      int  k;
      logic glitch;
      rst = 1'b1;
      bus.pll_lock = 1'b0; bus.sw_req = 1'b0; bus.sts_clr = 1'b0; bus.irq_en = 1'b1;

      // Reset state, then normal switch with lock stable from reset
      do_reset(1'b1);
      check_eq("rst_sel1", bus.sel1, 1'b0);
      check_eq("rst_busy", bus.busy, 1'b0);
      repeat (8) tick();
      bus.sw_req = 1'b1;
      tick_until(0, 1'b1, 100, n);
      check_eq("norm_sel1_lat", n, 1 + LOCK_WAIT);
      tick_until(1, 1'b1, 50, k);
      check_eq("norm_cur_lat", k, SETTLE_CYC);
      check_eq("norm_busy_low", bus.busy, 1'b0);
      check_eq("norm_no_status", {bus.lock_lost, bus.lock_tmo}, 2'b00);
      $display("normal switch: sel1 after %0d cycles, cur_sel %0d cycles later", n, k);

      // Lock loss while settled on clk1
      bus.pll_lock = 1'b0;
      tick_until(0, 1'b0, 20, n);
      check_eq("loss_sel1_lat", n, 3);
      check_eq("loss_lost", bus.lock_lost, 1'b1);
      tick_until(2, 1'b0, 30, k);
      check_eq("loss_busy_len", k, SETTLE_CYC);
      check_eq("loss_irq", bus.irq, 1'b1);
      bus.pll_lock = 1'b1;
      repeat (30) tick();
      check_eq("loss_no_rearm", bus.busy, 1'b0);
      $display("lock loss in SEL1: sel1 low after %0d cycles, busy %0d cycles", n, k);

      // Single-cycle lock glitch at lock_cnt=10
      do_reset(1'b1);
      bus.sw_req = 1'b1;
      tick();
      repeat (8) tick();
      bus.pll_lock = 1'b0;
      tick();
      bus.pll_lock = 1'b1;
      tick_until(0, 1'b1, 100, n);
      check_eq("glitch_sel1_lat", n + 9, LOCK_WAIT + 11);
      $display("lock glitch: sel1 %0d cycles after WAIT_LOCK entry", n + 9);

      // Lock loss during SW_TO1 when set_cnt=3
      do_reset(1'b1);
      bus.sw_req = 1'b1;
      tick_until(0, 1'b1, 100, n);
      tick();
      bus.pll_lock = 1'b0;
      tick();
      tick_until(0, 1'b0, 20, n);
      check_eq("sw1_loss_width", n + 2, 4);
      check_eq("sw1_loss_lost", bus.lock_lost, 1'b1);
      tick_until(2, 1'b0, 30, k);
      check_eq("sw1_loss_settle", k, SETTLE_CYC);
      $display("lock loss in SW_TO1: sel1 width %0d, settle %0d", n + 2, k);

      // sts_clr coinciding with the lock_lost set
      do_reset(1'b1);
      bus.sw_req = 1'b1;
      tick_until(1, 1'b1, 100, n);
      bus.pll_lock = 1'b0;
      tick();
      tick();
      bus.sts_clr = 1'b1;
      tick();
      bus.sts_clr = 1'b0;
      check_eq("clr_vs_set", bus.lock_lost, 1'b1);
      $display("sts_clr with lock loss: lock_lost=%0b", bus.lock_lost);

      // Reset asserted in SEL1
      do_reset(1'b1);
      bus.sw_req = 1'b1;
      tick_until(1, 1'b1, 100, n);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rst_in_sel1", {bus.sel1, bus.busy, bus.cur_sel}, 3'b000);
      $display("reset in SEL1: sel1=%0b busy=%0b cur_sel=%0b", bus.sel1, bus.busy, bus.cur_sel);

      // Timeout with no lock, no re-arm until sts_clr
      do_reset(1'b0);
      bus.sw_req = 1'b1;
      tick_until(3, 1'b1, 5000, n);
      check_eq("tmo_lat", n, 1 + TMO_CYC);
      check_eq("tmo_busy_low", bus.busy, 1'b0);
      repeat (10) tick();
      check_eq("tmo_no_rearm", bus.busy, 1'b0);
      bus.sts_clr = 1'b1;
      tick();
      bus.sts_clr = 1'b0;
      tick_until(2, 1'b1, 10, k);
      check_eq("tmo_rearm_lat", k, 1);
      $display("timeout: lock_tmo after %0d cycles, re-armed %0d cycle after clear", n, k);
      bus.sw_req = 1'b0;
      tick();

      // Randomized traffic
      glitch = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (glitch) begin
            bus.pll_lock = ~bus.pll_lock;
            glitch = 1'b0;
         end else if ($urandom_range(199) == 0) begin
            bus.pll_lock = ~bus.pll_lock;
            glitch = 1'b1;
         end else if ($urandom_range(59) == 0) begin
            bus.pll_lock = ~bus.pll_lock;
         end
         if ($urandom_range(149) == 0) bus.sw_req = ~bus.sw_req;
         bus.sts_clr = ($urandom_range(49) == 0);
         if ($urandom_range(299) == 0) bus.irq_en = ~bus.irq_en;
         rst = ($urandom_range(1999) == 0);
         tick();
      end
      $display("random traffic: 20000 cycles");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
